// File: rtl/dmem_store_monitor.sv
// rtl/dmem_store_monitor.sv - CPU data-port RAM responder with store log and pass/fail/timeout verdict
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   MemWrite             store strobe from the CPU
//   DataAddr, WriteData  byte address and data of the current load/store
//   ReadData             combinational load data (0 for an illegal address)
//   log_rd               pop the oldest store-log entry
//   log_valid            store log holds at least one entry
//   log_addr, log_data   oldest logged store (0 while the log is empty)
//   log_overflow         sticky: a store was dropped because the log was full
//   pass, fail, timeout  one-hot decode of the sticky run verdict
module dmem_store_monitor #(
    parameter int          DEPTH_WORDS    = 64,
    parameter int          LOG_DEPTH      = 8,
    parameter logic [31:0] PASS_ADDR      = 32'd104,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter int          TIMEOUT_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        log_rd,
    output logic        log_valid,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        log_overflow,
    output logic        pass,
    output logic        fail,
    output logic        timeout
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          LW        = $clog2(LOG_DEPTH);
    localparam int          CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    // ------------------------------------------------------------------
    // Word RAM: asynchronous read, write at the edge. Not cleared by reset,
    // so program results survive a reset for inspection.
    // ------------------------------------------------------------------
    logic [31:0]   mem [DEPTH_WORDS];
    logic          addrLegal;
    logic [AW-1:0] wordIdx;

    assign addrLegal = (DataAddr[1:0] == 2'b00) && (DataAddr < MEM_BYTES);
    assign wordIdx   = DataAddr[AW+1:2];
    assign ReadData  = addrLegal ? mem[wordIdx] : 32'd0;

    // The RAM write deliberately ignores reset: a store coinciding with
    // reset still lands in memory.
    always_ff @(posedge clk) begin
        if (MemWrite && addrLegal) begin
            mem[wordIdx] <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Store log FIFO
    // ------------------------------------------------------------------
    logic [31:0]   logAddrMem [LOG_DEPTH];
    logic [31:0]   logDataMem [LOG_DEPTH];
    logic [LW-1:0] wrPtr;
    logic [LW-1:0] rdPtr;
    logic [LW:0]   logCount;
    logic          logFull;
    logic          logEmpty;
    logic          doPush;
    logic          doPop;

    assign logFull  = (logCount == (LW+1)'(LOG_DEPTH));
    assign logEmpty = (logCount == '0);
    assign doPop    = log_rd && !logEmpty;
    // A simultaneous pop frees a slot, so a full log still accepts the push.
    assign doPush   = MemWrite && (!logFull || doPop);

    always_ff @(posedge clk) begin
        if (doPush && !reset) begin
            logAddrMem[wrPtr] <= DataAddr;
            logDataMem[wrPtr] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            logCount     <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   logCount <= logCount + 1'b1;
                2'b01:   logCount <= logCount - 1'b1;
                default: logCount <= logCount;
            endcase
            if (MemWrite && !doPush) begin
                log_overflow <= 1'b1;
            end
        end
    end

    assign log_valid = !logEmpty;
    assign log_addr  = log_valid ? logAddrMem[rdPtr] : 32'd0;
    assign log_data  = log_valid ? logDataMem[rdPtr] : 32'd0;

    // ------------------------------------------------------------------
    // Verdict FSM. A store-based verdict in the last RUN cycle takes
    // precedence over the timeout.
    // ------------------------------------------------------------------
    logic [1:0]    state;
    logic [1:0]    stateNext;
    logic [CW-1:0] cycleCount;

    always_comb begin
        stateNext = state;
        if (state == ST_RUN) begin
            if (MemWrite && !addrLegal) begin
                stateNext = ST_FAIL;
            end else if (MemWrite && (DataAddr == PASS_ADDR)) begin
                stateNext = (WriteData == PASS_DATA) ? ST_PASS : ST_FAIL;
            end else if (cycleCount == CW'(TIMEOUT_CYCLES - 1)) begin
                stateNext = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            cycleCount <= '0;
        end else begin
            state <= stateNext;
            if (state == ST_RUN) begin
                cycleCount <= cycleCount + 1'b1;
            end
        end
    end

    assign pass    = (state == ST_PASS);
    assign fail    = (state == ST_FAIL);
    assign timeout = (state == ST_TIMEOUT);

endmodule

// File: tb/tb_dmem_store_monitor.sv
// tb/tb_dmem_store_monitor.sv - self-checking bench for dmem_store_monitor
module tb_dmem_store_monitor;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAddr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        log_rd;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        log_overflow;
    logic        pass;
    logic        fail;
    logic        timeout;

    int tests = 0;
    int fails = 0;

    dmem_store_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .DataAddr     (DataAddr),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .log_rd       (log_rd),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_overflow (log_overflow),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: words written so far, a queue of logged stores,
    // verdict flags and the number of edges spent undecided since reset.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic [31:0] mMem [64];
    bit          mKnown [64];
    ent_t        mLog [$];
    bit          mOverflow;
    bit          mPass, mFail, mTimeout;
    int          mRunEdges;
    bit          modelOn = 0;

    function automatic bit isLegal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 256);
    endfunction

    task automatic modelStep();
        ent_t e;
        bit   popNow;
        if (MemWrite && isLegal(DataAddr)) begin
            mMem[DataAddr / 4]   = WriteData;
            mKnown[DataAddr / 4] = 1;
        end
        if (reset) begin
            mLog.delete();
            mOverflow = 0;
            mPass = 0; mFail = 0; mTimeout = 0;
            mRunEdges = 0;
            modelOn = 1;
        end else if (modelOn) begin
            popNow = log_rd && (mLog.size() > 0);
            if (popNow) void'(mLog.pop_front());
            if (MemWrite) begin
                if (mLog.size() >= 8) mOverflow = 1;
                else begin
                    e.a = DataAddr; e.d = WriteData;
                    mLog.push_back(e);
                end
            end
            if (!(mPass || mFail || mTimeout)) begin
                if (MemWrite && !isLegal(DataAddr)) mFail = 1;
                else if (MemWrite && DataAddr == 32'd104) begin
                    if (WriteData == 32'd25) mPass = 1;
                    else mFail = 1;
                end else if (mRunEdges + 1 == 100) mTimeout = 1;
                else mRunEdges++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Compare process: every negedge once the model has seen a reset.
    initial forever begin
        @(negedge clk);
        if (modelOn) begin
            check("m_pass", 32'(pass), 32'(mPass));
            check("m_fail", 32'(fail), 32'(mFail));
            check("m_timeout", 32'(timeout), 32'(mTimeout));
            check("m_log_overflow", 32'(log_overflow), 32'(mOverflow));
            check("m_log_valid", 32'(log_valid), 32'(mLog.size() > 0));
            if (mLog.size() > 0) begin
                check("m_log_addr", log_addr, mLog[0].a);
                check("m_log_data", log_data, mLog[0].d);
            end
            if (!isLegal(DataAddr)) check("m_readdata_illegal", ReadData, 32'd0);
            else if (mKnown[DataAddr / 4]) check("m_readdata", ReadData, mMem[DataAddr / 4]);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus; inputs change 1 time unit after each rising edge.
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; DataAddr = a; WriteData = d;
        cyc();
        MemWrite = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1; MemWrite = 1'b0; log_rd = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic popCheck(input logic [31:0] a, input logic [31:0] d);
        check("pop_valid", 32'(log_valid), 32'd1);
        check("pop_addr", log_addr, a);
        check("pop_data", log_data, d);
        log_rd = 1'b1;
        cyc();
        log_rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; DataAddr = '0; WriteData = '0; log_rd = 1'b0;
        cyc();
        doReset();
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_log_valid", 32'(log_valid), 32'd0);
        check("rst_log_overflow", 32'(log_overflow), 32'd0);
        check("rst_log_addr", log_addr, 32'd0);
        check("rst_log_data", log_data, 32'd0);

        // Passing program, then drain the log
        store(32'd0, 32'd7);
        store(32'd4, 32'd11);
        check("a_pass_early", 32'(pass), 32'd0);
        store(32'd104, 32'd25);
        check("a_pass", 32'(pass), 32'd1);
        check("a_rd104", ReadData, 32'd25);
        popCheck(32'd0, 32'd7);
        popCheck(32'd4, 32'd11);
        popCheck(32'd104, 32'd25);
        check("a_log_empty", 32'(log_valid), 32'd0);
        log_rd = 1'b1; cyc(); log_rd = 1'b0;
        check("a_pop_empty", 32'(log_valid), 32'd0);

        // Wrong completion data, later correct store ignored
        doReset();
        store(32'd104, 32'd24);
        check("b_fail", 32'(fail), 32'd1);
        store(32'd104, 32'd25);
        check("b_pass_stays0", 32'(pass), 32'd0);
        check("b_fail_stays1", 32'(fail), 32'd1);

        // Illegal stores
        doReset();
        store(32'd258, 32'hAA);
        check("c_fail_misaligned", 32'(fail), 32'd1);
        store(32'd256, 32'hBB);
        DataAddr = 32'd256; #1;
        check("c_rd256", ReadData, 32'd0);
        DataAddr = 32'd0; #1;
        check("c_rd0_unchanged", ReadData, 32'd7);
        popCheck(32'd258, 32'hAA);
        popCheck(32'd256, 32'hBB);

        // Timeout boundary
        doReset();
        repeat (99) cyc();
        check("d_timeout_99", 32'(timeout), 32'd0);
        cyc();
        check("d_timeout_100", 32'(timeout), 32'd1);
        doReset();
        repeat (99) cyc();
        store(32'd104, 32'd25);
        check("d_pass_at_100", 32'(pass), 32'd1);
        check("d_no_timeout", 32'(timeout), 32'd0);

        // Overflow: 9 stores, first 8 held
        doReset();
        for (int i = 0; i < 9; i++) store(32'(i * 4), 32'(100 + i));
        check("e_overflow", 32'(log_overflow), 32'd1);
        for (int i = 0; i < 8; i++) popCheck(32'(i * 4), 32'(100 + i));
        check("e_drained", 32'(log_valid), 32'd0);

        // Full log with simultaneous push and pop
        doReset();
        for (int i = 0; i < 8; i++) store(32'(i * 4), 32'(100 + i));
        check("f_no_overflow_full", 32'(log_overflow), 32'd0);
        MemWrite = 1'b1; DataAddr = 32'd200; WriteData = 32'd77; log_rd = 1'b1;
        cyc();
        MemWrite = 1'b0; log_rd = 1'b0;
        check("f_no_overflow_pp", 32'(log_overflow), 32'd0);
        for (int i = 1; i < 8; i++) popCheck(32'(i * 4), 32'(100 + i));
        popCheck(32'd200, 32'd77);
        check("f_drained", 32'(log_valid), 32'd0);

        // Reset after PASS, and reset colliding with stores
        doReset();
        store(32'd104, 32'd25);
        check("g_pass", 32'(pass), 32'd1);
        doReset();
        check("g_pass_cleared", 32'(pass), 32'd0);
        check("g_log_empty", 32'(log_valid), 32'd0);
        DataAddr = 32'd104; #1;
        check("g_rd104_kept", ReadData, 32'd25);
        reset = 1'b1; MemWrite = 1'b1; DataAddr = 32'd8; WriteData = 32'd5;
        cyc();
        DataAddr = 32'd104; WriteData = 32'd25;
        cyc();
        reset = 1'b0; MemWrite = 1'b0;
        check("g_rst_store_nolog", 32'(log_valid), 32'd0);
        check("g_rst_store_nopass", 32'(pass), 32'd0);
        DataAddr = 32'd8; #1;
        check("g_rst_store_ram", ReadData, 32'd5);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
